// File: rtl/task_arbiter.sv
// Round-robin task arbiter: grants one channel at a time until it reports done or
// the watchdog expires, then leaves one idle cycle before the next grant.
module task_arbiter #(
  parameter int unsigned N_TASKS        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          SKIP_IDLE      = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_TASKS-1:0]         req,
  input  logic [N_TASKS-1:0]         done,
  output logic [N_TASKS-1:0]         grant,
  output logic [$clog2(N_TASKS)-1:0] cur_id,
  output logic                       busy,
  output logic                       timeout,
  output logic [$clog2(N_TASKS)-1:0] timeout_id,
  output logic                       spurious
);

  localparam int unsigned    IDW     = $clog2(N_TASKS);
  localparam logic [15:0]    TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_TASKS - 1);

  typedef enum logic [1:0] {ARB, GRANT, GAP} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       cur_id_q, cur_id_d;
  logic [IDW-1:0]       tid_q, tid_d;
  logic [N_TASKS-1:0]   grant_q, grant_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 spurious_q, spurious_d;

  logic [N_TASKS-1:0]   eligible;
  logic                 pick_vld;
  logic [IDW-1:0]       pick_id;
  logic [IDW-1:0]       next_id;

  // Without SKIP_IDLE every channel is eligible, so the search lands on ptr itself.
  assign eligible = req | {N_TASKS{!SKIP_IDLE}};
  assign next_id  = (cur_id_q == LAST_ID) ? '0 : cur_id_q + 1'b1;

  always_comb begin
    logic [IDW-1:0] idx;
    pick_vld = 1'b0;
    pick_id  = ptr_q;
    idx      = '0;
    for (int unsigned i = 0; i < N_TASKS; i++) begin
      idx = IDW'((32'(ptr_q) + i) % N_TASKS);
      if (!pick_vld && eligible[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    cur_id_d   = cur_id_q;
    cnt_d      = cnt_q;
    tid_d      = tid_q;
    timeout_d  = 1'b0;
    spurious_d = |(done & ~grant_q);
    case (state_q)
      ARB, GAP: begin
        grant_d = '0;
        if (pick_vld) begin
          grant_d[pick_id] = 1'b1;
          cur_id_d         = pick_id;
          cnt_d            = '0;
          state_d          = GRANT;
        end else begin
          state_d = ARB;
        end
      end
      GRANT: begin
        // done beats a coincident watchdog expiry
        if (done[cur_id_q]) begin
          grant_d = '0;
          ptr_d   = next_id;
          state_d = GAP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
          grant_d   = '0;
          ptr_d     = next_id;
          timeout_d = 1'b1;
          tid_d     = cur_id_q;
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      grant_q    <= '0;
      cur_id_q   <= '0;
      cnt_q      <= '0;
      tid_q      <= '0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      cur_id_q   <= cur_id_d;
      cnt_q      <= cnt_d;
      tid_q      <= tid_d;
      timeout_q  <= timeout_d;
      spurious_q <= spurious_d;
    end
  end

  assign grant      = grant_q;
  assign cur_id     = cur_id_q;
  assign busy       = |grant_q;
  assign timeout    = timeout_q;
  assign timeout_id = tid_q;
  assign spurious   = spurious_q;

endmodule

// File: tb/tb_task_arbiter.sv
// Bench for task_arbiter: transaction-level model of grant order, grant length,
// watchdog and spurious-done behaviour across three parameterisations.
module tb_task_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] req0, done0, grant0, req1, done1, grant1;
  logic [1:0] cur0, tid0, cur1, tid1, req2, done2, grant2;
  logic [0:0] cur2, tid2;
  logic       busy0, to0, sp0, busy1, to1, sp1, busy2, to2, sp2;

  task_arbiter #(.N_TASKS(4), .TIMEOUT_CYCLES(16), .SKIP_IDLE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .done(done0), .grant(grant0), .cur_id(cur0),
    .busy(busy0), .timeout(to0), .timeout_id(tid0), .spurious(sp0));

  task_arbiter #(.N_TASKS(4), .TIMEOUT_CYCLES(16), .SKIP_IDLE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .done(done1), .grant(grant1), .cur_id(cur1),
    .busy(busy1), .timeout(to1), .timeout_id(tid1), .spurious(sp1));

  task_arbiter #(.N_TASKS(2), .TIMEOUT_CYCLES(0), .SKIP_IDLE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .done(done2), .grant(grant2), .cur_id(cur2),
    .busy(busy2), .timeout(to2), .timeout_id(tid2), .spurious(sp2));

  int n_tests = 0;
  int n_fail  = 0;
  int ch0_exp, tid0_exp, ptr1_exp, tid1_exp, ch2_exp;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    done0 = '0; done1 = '0; done2 = '0;
    req0 = '0; req1 = '0; req2 = '0;
    tick; tick;
    rst = 1'b0;
    ch0_exp = 0; tid0_exp = 0; ptr1_exp = 0; tid1_exp = 0; ch2_exp = 0;
  endtask

  // One grant on dut0: done arrives on grant cycle d (d>16 means never -> timeout).
  // spur >= 0 pulses done on that other channel during grant cycle 1.
  task automatic dut0_txn(input int d, input int spur);
    int L;
    logic [3:0] eg;
    logic [8:0] act9, exp9;
    logic [6:0] act7, exp7;
    logic [5:0] act6, exp6;
    L = (d > 16) ? 16 : d;
    eg = 4'b0001 << ch0_exp;
    req0 = 4'($urandom);
    tick;
    act9 = {grant0, busy0, cur0, to0, sp0};
    exp9 = {eg, 1'b1, 2'(ch0_exp), 1'b0, 1'b0};
    n_tests++;
    if (act9 !== exp9) begin
      n_fail++;
      $display("FAIL d0_grant_entry: got %b want %b (grant,busy,cur,to,sp)", act9, exp9);
    end
    for (int k = 1; k < L; k++) begin
      if (k == 1 && spur >= 0) done0[spur] = 1'b1;
      tick;
      done0 = '0;
      act6 = {grant0, to0, sp0};
      exp6 = {eg, 1'b0, (k == 1 && spur >= 0)};
      n_tests++;
      if (act6 !== exp6) begin
        n_fail++;
        $display("FAIL d0_grant_hold k=%0d: got %b want %b (grant,to,sp)", k, act6, exp6);
      end
    end
    if (d <= 16) done0[ch0_exp] = 1'b1;
    tick;
    done0 = '0;
    if (d > 16) tid0_exp = ch0_exp;
    act9 = {grant0, busy0, to0, tid0, sp0};
    exp9 = {4'b0000, 1'b0, (d > 16), 2'(tid0_exp), 1'b0};
    n_tests++;
    if (act9 !== exp9) begin
      n_fail++;
      $display("FAIL d0_gap: got %b want %b (grant,busy,to,tid,sp)", act9, exp9);
    end
    ch0_exp = (ch0_exp + 1) % 4;
    act7 = '0; exp7 = '0;
  endtask

  // One arbitration on dut1 with request vector r; r==0 checks it stays idle.
  task automatic dut1_txn(input logic [3:0] r, input int d);
    int L, ch;
    bit found;
    logic [3:0] eg;
    logic [6:0] act7, exp7;
    logic [4:0] act5, exp5;
    req1 = r;
    if (r == 4'b0000) begin
      for (int k = 0; k < 3; k++) begin
        tick;
        n_tests++;
        if ({grant1, busy1} !== 5'b00000) begin
          n_fail++;
          $display("FAIL d1_idle: got %b want 00000 (grant,busy)", {grant1, busy1});
        end
      end
      return;
    end
    found = 1'b0; ch = 0;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (ptr1_exp + i) % 4;
      if (!found && r[c]) begin found = 1'b1; ch = c; end
    end
    eg = 4'b0001 << ch;
    L = (d > 16) ? 16 : d;
    tick;
    act7 = {grant1, busy1, cur1};
    exp7 = {eg, 1'b1, 2'(ch)};
    n_tests++;
    if (act7 !== exp7) begin
      n_fail++;
      $display("FAIL d1_grant_entry req=%b: got %b want %b (grant,busy,cur)", r, act7, exp7);
    end
    for (int k = 1; k < L; k++) begin
      tick;
      act5 = {grant1, to1};
      exp5 = {eg, 1'b0};
      n_tests++;
      if (act5 !== exp5) begin
        n_fail++;
        $display("FAIL d1_grant_hold k=%0d: got %b want %b (grant,to)", k, act5, exp5);
      end
    end
    if (d <= 16) done1[ch] = 1'b1;
    tick;
    done1 = '0;
    if (d > 16) tid1_exp = ch;
    act7 = {grant1, to1, tid1};
    exp7 = {4'b0000, (d > 16), 2'(tid1_exp)};
    n_tests++;
    if (act7 !== exp7) begin
      n_fail++;
      $display("FAIL d1_gap: got %b want %b (grant,to,tid)", act7, exp7);
    end
    ptr1_exp = (ch + 1) % 4;
  endtask

  task automatic test_reset;
    logic [11:0] act;
    rst = 1'b1;
    done0 = '1; done1 = '1; done2 = '1;
    tick; tick;
    act = {grant0, busy0, cur0, to0, tid0, sp0, busy1, sp1};
    n_tests++;
    if (act !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000000000", act);
    end
    n_tests++;
    if ({grant1, grant2, busy2, sp2} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_grants: got %b want 000000000", {grant1, grant2, busy2, sp2});
    end
    do_reset;
  endtask

  task automatic test_rotation;
    do_reset;
    for (int i = 0; i < 5; i++) dut0_txn(3, -1);
  endtask

  task automatic test_timeout;
    do_reset;
    dut0_txn(1, -1);
    dut0_txn(1, -1);
    dut0_txn(40, -1);
    dut0_txn(2, -1);
  endtask

  task automatic test_done_vs_timeout;
    do_reset;
    dut0_txn(2, -1);
    dut0_txn(16, -1);
    dut0_txn(1, -1);
  endtask

  task automatic test_spurious;
    do_reset;
    dut0_txn(5, 3);
  endtask

  task automatic test_reset_mid_grant;
    do_reset;
    dut0_txn(1, -1);
    dut0_txn(1, -1);
    tick;
    n_tests++;
    if (grant0 !== 4'b0100) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got %b want 0100", grant0);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({grant0, busy0} !== 5'b00000) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %b want 00000", {grant0, busy0});
    end
    rst = 1'b0;
    ch0_exp = 0; tid0_exp = 0;
    dut0_txn(2, -1);
  endtask

  task automatic test_skip_idle;
    do_reset;
    dut1_txn(4'b1010, 2);
    dut1_txn(4'b1010, 2);
    dut1_txn(4'b1010, 2);
    dut1_txn(4'b0000, 1);
    dut1_txn(4'b0100, 30);
  endtask

  task automatic test_two_task;
    logic [1:0] eg;
    do_reset;
    for (int t = 0; t < 6; t++) begin
      int d;
      d = $urandom_range(1, 30);
      eg = 2'b01 << ch2_exp;
      tick;
      n_tests++;
      if ({grant2, cur2, busy2} !== {eg, 1'(ch2_exp), 1'b1}) begin
        n_fail++;
        $display("FAIL n2_grant: got %b want %b", {grant2, cur2, busy2}, {eg, 1'(ch2_exp), 1'b1});
      end
      for (int k = 1; k < d; k++) begin
        tick;
        n_tests++;
        if ({grant2, to2} !== {eg, 1'b0}) begin
          n_fail++;
          $display("FAIL n2_hold k=%0d: got %b want %b", k, {grant2, to2}, {eg, 1'b0});
        end
      end
      done2[ch2_exp] = 1'b1;
      tick;
      done2 = '0;
      n_tests++;
      if ({grant2, to2} !== 3'b000) begin
        n_fail++;
        $display("FAIL n2_gap: got %b want 000", {grant2, to2});
      end
      ch2_exp = 1 - ch2_exp;
    end
  endtask

  task automatic test_random;
    do_reset;
    for (int t = 0; t < 20; t++) begin
      int d, spur;
      d = $urandom_range(1, 20);
      spur = -1;
      if (d >= 2 && $urandom_range(0, 2) == 0) spur = (ch0_exp + $urandom_range(1, 3)) % 4;
      dut0_txn(d, spur);
    end
    do_reset;
    for (int t = 0; t < 20; t++) dut1_txn(4'($urandom_range(0, 15)), $urandom_range(1, 20));
  endtask

  initial begin
    rst = 1'b1;
    done0 = '0; done1 = '0; done2 = '0;
    req0 = '0; req1 = '0; req2 = '0;
    test_reset;
    test_rotation;
    test_timeout;
    test_done_vs_timeout;
    test_spurious;
    test_reset_mid_grant;
    test_skip_idle;
    test_two_task;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/task_arbiter.md
TASK_ARBITER -- requirements
Module: task_arbiter

Interface
REQ-001 Parameter N_TASKS, default 4: number of task channels, range 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: watchdog limit in clocks per grant; 0 disables the watchdog; range 0..65535.
REQ-003 Parameter SKIP_IDLE, default 0: 0 = every channel granted in strict rotation regardless of req; 1 = only channels with req high are granted.
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  N_TASKS  per-channel request level; used only when SKIP_IDLE=1.
REQ-007 done  input  N_TASKS  per-channel completion, sampled on posedge; a one-cycle or multi-cycle level is accepted.
REQ-008 grant  output  N_TASKS  one-hot-or-zero grant, registered.
REQ-009 cur_id  output  clog2(N_TASKS)  index of the granted channel; valid while busy=1.
REQ-010 busy  output  1  high while any grant bit is high.
REQ-011 timeout  output  1  one-cycle pulse when the watchdog revokes a grant.
REQ-012 timeout_id  output  clog2(N_TASKS)  channel revoked by the last timeout; held until the next timeout.
REQ-013 spurious  output  1  one-cycle pulse when done is high on any non-granted channel.

Function
REQ-014 The FSM states shall be ARB, GRANT and GAP; rotation pointer ptr is clog2(N_TASKS) bits.
REQ-015 In ARB with SKIP_IDLE=0, the block shall grant channel ptr at the next edge and enter GRANT.
REQ-016 In ARB with SKIP_IDLE=1, the block shall grant the first channel with req high, searching ptr, ptr+1, ... mod N_TASKS, and enter GRANT; with no req it shall stay in ARB with grant=0.
REQ-017 At most one grant bit shall be high in any cycle; grant and cur_id shall change only on the edge that enters or leaves GRANT.
REQ-018 On entry to GRANT, the watchdog counter shall be cleared to 0; it shall increment once per cycle spent in GRANT.
REQ-019 In GRANT, when done[cur_id]=1 at an edge, grant shall go to 0 at that edge, ptr shall become cur_id+1 mod N_TASKS, and the FSM shall enter GAP.
REQ-020 In GRANT, with TIMEOUT_CYCLES>0 and done[cur_id]=0, when the counter equals TIMEOUT_CYCLES-1 at an edge, the block shall revoke the grant, pulse timeout for one cycle, load timeout_id=cur_id, advance ptr as in REQ-019, and enter GAP.
REQ-021 If done and the watchdog expiry coincide at the same edge, done shall win: no timeout pulse and timeout_id unchanged.
REQ-022 GAP shall last exactly one cycle with grant=0, and arbitration shall then proceed as in ARB; a done-to-next-grant gap shall therefore be exactly one all-zero cycle.
REQ-023 A done bit high on a non-granted channel, in any state, shall pulse spurious for one cycle and shall not otherwise affect state.
REQ-024 A done bit that is still high in GAP or ARB shall not retire the next grant; only a done sampled while in GRANT for the granted channel shall count.
REQ-025 ptr shall wrap from N_TASKS-1 to 0.
REQ-026 For N_TASKS=2, SKIP_IDLE=0 and TIMEOUT_CYCLES=0, the block shall behave as the two-task alternating dispatcher: grant0, done0, gap, grant1, done1, gap, and so on.

Reset
REQ-027 While rst=1: grant=0, busy=0, cur_id=0, timeout=0, timeout_id=0, spurious=0, ptr=0, state=ARB, counter=0.
REQ-028 Reset asserted mid-grant shall drop grant immediately (asynchronously); after release, arbitration shall restart from channel 0.

Verification
REQ-029 N=4, SKIP_IDLE=0: done pulsed 3 cycles after each grant -> grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one zero cycle between grants.
REQ-030 SKIP_IDLE=1, req=1010, ptr=0 -> grant 0010, then 1000 after done, then 0010; channels 0 and 2 are never granted.
REQ-031 TIMEOUT_CYCLES=16, no done on channel 2 -> grant 0100 held for 16 cycles, then timeout=1 for one cycle, timeout_id=2, next grant 1000.
REQ-032 done[1] high in the same cycle as watchdog expiry on channel 1 -> no timeout pulse, normal advance to channel 2.
REQ-033 done[3] pulsed while channel 0 is granted -> spurious=1 for one cycle; grant stays 0001.
REQ-034 rst pulsed while grant=0100 -> grant=0 immediately; after release the first grant is 0001.
